// File: rtl/mem_arb_pkg.sv
// Shared definitions for the three-way memory port arbiter: requester indices,
// mux select encodings (matching the 3:1 mux data ordering) and the FSM state type.
package mem_arb_pkg;

  localparam int IF_ID  = 0;
  localparam int MEM_ID = 1;
  localparam int DBG_ID = 2;

  localparam logic [1:0] SEL_IF  = 2'b00;
  localparam logic [1:0] SEL_MEM = 2'b01;
  localparam logic [1:0] SEL_DBG = 2'b10;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester/memory-side signal bundle of the arbiter; master drives requests,
// slave (the arbiter) drives grant, select and memory strobes.
interface mem_port_arbiter_if;
  logic [2:0] req_i;
  logic [2:0] we_i;
  logic [1:0] sel_o;
  logic [2:0] gnt_o;
  logic       mem_en_o;
  logic       mem_we_o;
  logic [2:0] done_o;
  logic       busy_o;

  modport master (
    output req_i, we_i,
    input  sel_o, gnt_o, mem_en_o, mem_we_o, done_o, busy_o
  );

  modport slave (
    input  req_i, we_i,
    output sel_o, gnt_o, mem_en_o, mem_we_o, done_o, busy_o
  );
endinterface

// File: rtl/mem_arb_pick.sv
// Combinational winner selection: MEM > IF > DBG, except that a starved DBG
// (age limit reached) wins outright while it is requesting.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic [2:0] req,
  input  logic       age_lim,
  output logic [2:0] win,
  output logic [1:0] sel
);

  always_comb begin
    win = 3'b000;
    sel = SEL_IF;
    if (age_lim && req[DBG_ID]) begin
      win[DBG_ID] = 1'b1;
      sel         = SEL_DBG;
    end else if (req[MEM_ID]) begin
      win[MEM_ID] = 1'b1;
      sel         = SEL_MEM;
    end else if (req[IF_ID]) begin
      win[IF_ID] = 1'b1;
      sel        = SEL_IF;
    end else if (req[DBG_ID]) begin
      win[DBG_ID] = 1'b1;
      sel         = SEL_DBG;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter for IF / MEM / DBG with fixed-latency access sequencing.
//   state  | meaning
//   IDLE   | no access in flight; arbitrate every cycle a request is present
//   ACCESS | MEM_LAT-cycle access; last cycle pulses done and re-arbitrates
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MEM_LAT    = 2,
  parameter int STARVE_LIM = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  mem_port_arbiter_if.slave bus
);

  localparam logic [3:0] LAT_LAST = 4'(MEM_LAT - 1);
  localparam logic [7:0] AGE_MAX  = 8'(STARVE_LIM);

  state_t     state_q, state_d;
  logic [3:0] lat_cnt_q, lat_cnt_d;
  logic [7:0] age_q, age_d;
  logic [2:0] gnt_q, gnt_d;
  logic [1:0] sel_q, sel_d;
  logic       en_q, en_d;
  logic       we_q, we_d;

  logic       last;
  logic       decide;
  logic       age_lim;
  logic [2:0] req_m;
  logic [2:0] win;
  logic [1:0] win_sel;

  assign last    = (state_q == ACCESS) && (lat_cnt_q == LAT_LAST);
  assign decide  = (state_q == IDLE) || last;
  // the completing requester sits out the overlapping decision
  assign req_m   = bus.req_i & ~(last ? gnt_q : 3'b000);
  assign age_lim = (age_q == AGE_MAX);

  mem_arb_pick u_pick (
    .req     (req_m),
    .age_lim (age_lim),
    .win     (win),
    .sel     (win_sel)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q   <= IDLE;
      lat_cnt_q <= 4'd0;
      age_q     <= 8'd0;
      gnt_q     <= 3'b000;
      sel_q     <= SEL_IF;
      en_q      <= 1'b0;
      we_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      lat_cnt_q <= lat_cnt_d;
      age_q     <= age_d;
      gnt_q     <= gnt_d;
      sel_q     <= sel_d;
      en_q      <= en_d;
      we_q      <= we_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    lat_cnt_d = lat_cnt_q;
    age_d     = age_q;
    gnt_d     = gnt_q;
    sel_d     = sel_q;
    en_d      = 1'b0;
    we_d      = 1'b0;
    if (decide) begin
      if (req_m[DBG_ID] && !win[DBG_ID]) begin
        if (!age_lim) age_d = age_q + 8'd1;
      end else begin
        age_d = 8'd0;
      end
      lat_cnt_d = 4'd0;
      if (|req_m) begin
        state_d = ACCESS;
        gnt_d   = win;
        sel_d   = win_sel;
        en_d    = 1'b1;
        we_d    = |(bus.we_i & win);
      end else begin
        // sel is left alone so the address mux stays stable while idle
        state_d = IDLE;
        gnt_d   = 3'b000;
      end
    end else begin
      lat_cnt_d = lat_cnt_q + 4'd1;
    end
  end

  assign bus.sel_o    = sel_q;
  assign bus.gnt_o    = gnt_q;
  assign bus.mem_en_o = en_q;
  assign bus.mem_we_o = we_q;
  assign bus.done_o   = last ? gnt_q : 3'b000;
  assign bus.busy_o   = (state_q == ACCESS);

  always_ff @(posedge clk_i) begin
    param_range: assert (MEM_LAT >= 1 && MEM_LAT <= 15 && STARVE_LIM >= 1 && STARVE_LIM <= 255)
      else $error("mem_port_arbiter: MEM_LAT=%0d or STARVE_LIM=%0d out of range", MEM_LAT, STARVE_LIM);
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: two instances (MEM_LAT=2/STARVE_LIM=3 and MEM_LAT=1/STARVE_LIM=8)
// checked every cycle against a transaction-level reference model.
module tb_mem_port_arbiter;

  logic clk   = 1'b0;
  logic rst_b = 1'b0;
  always #5 clk = ~clk;

  mem_port_arbiter_if bus_a ();
  mem_port_arbiter_if bus_b ();

  mem_port_arbiter #(.MEM_LAT(2), .STARVE_LIM(3)) u_dut_a (
    .clk_i (clk),
    .rst_i (rst_b),
    .bus   (bus_a)
  );

  mem_port_arbiter #(.MEM_LAT(1), .STARVE_LIM(8)) u_dut_b (
    .clk_i (clk),
    .rst_i (rst_b),
    .bus   (bus_b)
  );

  int lat [2] = '{2, 1};
  int lim [2] = '{3, 8};

  // model: an access is "active" for lat cycles; m_left counts cycles still to go
  bit m_active [2];
  int m_win    [2];
  int m_left   [2];
  int m_age    [2];
  bit m_first  [2];
  bit m_wbit   [2];
  int m_sel    [2];

  int errs   = 0;
  int checks = 0;

  task automatic chk(string tag, logic [7:0] got, logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_active[k] = 1'b0;
      m_win[k]    = 0;
      m_left[k]   = 0;
      m_age[k]    = 0;
      m_first[k]  = 1'b0;
      m_wbit[k]   = 1'b0;
      m_sel[k]    = 0;
    end
  endtask

  task automatic model_step(int k, logic [2:0] req, logic [2:0] we);
    logic [2:0] m;
    int w;
    if (!m_active[k] || m_left[k] == 1) begin
      m = req;
      if (m_active[k]) m[m_win[k]] = 1'b0;
      w = -1;
      if (m[2] && m_age[k] == lim[k]) w = 2;
      else if (m[1]) w = 1;
      else if (m[0]) w = 0;
      else if (m[2]) w = 2;
      if (m[2] && w != 2) m_age[k] = (m_age[k] < lim[k]) ? m_age[k] + 1 : lim[k];
      else m_age[k] = 0;
      if (w >= 0) begin
        m_active[k] = 1'b1;
        m_win[k]    = w;
        m_left[k]   = lat[k];
        m_first[k]  = 1'b1;
        m_wbit[k]   = we[w];
        m_sel[k]    = w;
      end else begin
        m_active[k] = 1'b0;
        m_first[k]  = 1'b0;
      end
    end else begin
      m_left[k]  = m_left[k] - 1;
      m_first[k] = 1'b0;
    end
  endtask

  function automatic logic [2:0] exp_gnt(int k);
    return m_active[k] ? 3'(1 << m_win[k]) : 3'b000;
  endfunction

  function automatic logic [2:0] exp_done(int k);
    return (m_active[k] && m_left[k] == 1) ? 3'(1 << m_win[k]) : 3'b000;
  endfunction

  task automatic cmp_all();
    chk("a.sel",    8'(bus_a.sel_o),    8'(m_sel[0]));
    chk("a.gnt",    8'(bus_a.gnt_o),    8'(exp_gnt(0)));
    chk("a.mem_en", 8'(bus_a.mem_en_o), 8'(m_active[0] && m_first[0]));
    chk("a.mem_we", 8'(bus_a.mem_we_o), 8'(m_active[0] && m_first[0] && m_wbit[0]));
    chk("a.done",   8'(bus_a.done_o),   8'(exp_done(0)));
    chk("a.busy",   8'(bus_a.busy_o),   8'(m_active[0]));
    chk("b.sel",    8'(bus_b.sel_o),    8'(m_sel[1]));
    chk("b.gnt",    8'(bus_b.gnt_o),    8'(exp_gnt(1)));
    chk("b.mem_en", 8'(bus_b.mem_en_o), 8'(m_active[1] && m_first[1]));
    chk("b.mem_we", 8'(bus_b.mem_we_o), 8'(m_active[1] && m_first[1] && m_wbit[1]));
    chk("b.done",   8'(bus_b.done_o),   8'(exp_done(1)));
    chk("b.busy",   8'(bus_b.busy_o),   8'(m_active[1]));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step(0, bus_a.req_i, bus_a.we_i);
    model_step(1, bus_b.req_i, bus_b.we_i);
    #1;
    cmp_all();
  endtask

  // requesters mostly hold until done; rarely withdraw early to exercise mid-access drops
  function automatic logic [2:0] next_req(logic [2:0] cur, logic [2:0] done);
    logic [2:0] r;
    r = cur;
    for (int i = 0; i < 3; i++) begin
      if (cur[i]) begin
        if (done[i]) r[i] = ($urandom_range(0, 2) == 0);
        else if ($urandom_range(0, 40) == 0) r[i] = 1'b0;
      end else if ($urandom_range(0, 3) == 0) begin
        r[i] = 1'b1;
      end
    end
    return r;
  endfunction

  logic [1:0] seq_sel [$];
  logic [2:0] seq_gnt [$];
  logic [1:0] exp_seq [3] = '{2'b01, 2'b00, 2'b10};
  logic [2:0] exp_stv [4] = '{3'b010, 3'b001, 3'b010, 3'b100};
  int busy_cnt;
  int en_cnt;
  int done_cnt;

  initial begin
    bus_a.req_i = 3'b000;
    bus_a.we_i  = 3'b000;
    bus_b.req_i = 3'b000;
    bus_b.we_i  = 3'b000;
    model_reset();

    // reset values, then 10 quiet cycles
    repeat (2) @(posedge clk);
    #1;
    cmp_all();
    rst_b = 1'b1;
    repeat (10) tick();
    chk("idle.busy", 8'(bus_a.busy_o), 8'd0);

    // single IF access
    bus_a.req_i = 3'b001;
    tick();
    chk("if.en", 8'(bus_a.mem_en_o), 8'd1);
    tick();
    chk("if.done", 8'(bus_a.done_o), 8'b001);
    bus_a.req_i = 3'b000;
    tick();
    chk("if.idle", 8'(bus_a.busy_o), 8'd0);

    // all three at once, each drops after its done
    bus_a.req_i = 3'b111;
    bus_a.we_i  = 3'b010;
    busy_cnt = 0;
    for (int c = 0; c < 7; c++) begin
      tick();
      if (bus_a.mem_en_o) seq_sel.push_back(bus_a.sel_o);
      if (c == 0) chk("b2b.we", 8'(bus_a.mem_we_o), 8'd1);
      if (bus_a.busy_o) busy_cnt++;
      bus_a.req_i = bus_a.req_i & ~exp_done(0);
    end
    chk("b2b.n", 8'(seq_sel.size()), 8'd3);
    chk("b2b.busy", 8'(busy_cnt), 8'd6);
    for (int i = 0; i < 3 && i < seq_sel.size(); i++) chk("b2b.sel", 8'(seq_sel[i]), 8'(exp_seq[i]));
    bus_a.we_i = 3'b000;
    repeat (2) tick();

    // starvation: all held continuously, DBG must win the 4th decision
    bus_a.req_i = 3'b111;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (bus_a.mem_en_o) seq_gnt.push_back(bus_a.gnt_o);
    end
    chk("stv.n", 8'(seq_gnt.size()), 8'd4);
    for (int i = 0; i < 4 && i < seq_gnt.size(); i++) chk("stv.gnt", 8'(seq_gnt[i]), 8'(exp_stv[i]));
    bus_a.req_i = 3'b000;
    repeat (3) tick();

    // MEM_LAT=1 instance with IF always requesting
    bus_b.req_i = 3'b001;
    en_cnt = 0;
    done_cnt = 0;
    for (int c = 0; c < 8; c++) begin
      tick();
      chk("lat1.en_done", 8'(bus_b.mem_en_o), 8'(bus_b.done_o[0]));
      if (bus_b.mem_en_o) en_cnt++;
      if (bus_b.done_o[0]) done_cnt++;
    end
    chk("lat1.en_cnt", 8'(en_cnt), 8'd4);
    chk("lat1.done_cnt", 8'(done_cnt), 8'd4);
    bus_b.req_i = 3'b000;
    repeat (2) tick();

    // reset in the second cycle of a DBG access
    bus_a.req_i = 3'b100;
    tick();
    tick();
    rst_b = 1'b0;
    model_reset();
    #1;
    cmp_all();
    chk("rst.done", 8'(bus_a.done_o), 8'd0);
    @(posedge clk);
    #1;
    cmp_all();
    rst_b = 1'b1;
    done_cnt = 0;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (bus_a.done_o[2]) done_cnt++;
      bus_a.req_i = bus_a.req_i & ~exp_done(0);
    end
    chk("rst.redo", 8'(done_cnt), 8'd1);

    // randomized traffic on both instances
    for (int c = 0; c < 3000; c++) begin
      tick();
      bus_a.req_i = next_req(bus_a.req_i, exp_done(0));
      bus_b.req_i = next_req(bus_b.req_i, exp_done(1));
      bus_a.we_i  = 3'($urandom_range(0, 7));
      bus_b.we_i  = 3'($urandom_range(0, 7));
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
